lenet_stage_sequencer: RTL

LENET_STAGE_SEQUENCER -- requirements
Module: lenet_stage_sequencer

---
 rtl/lenet_stage_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lenet_stage_sequencer.sv
// Valid/settle sequencer for the four LeNet pipeline registers (image, conv2 in, conv3 in, output).
// Optional performance counters are built when LENET_SEQ_PERF_EN is defined.
module lenet_stage_sequencer #(
  parameter int S1_CYC = 3,
  parameter int S2_CYC = 2,
  parameter int S3_CYC = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [3:0] load_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
`ifdef LENET_SEQ_PERF_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] stall_cnt
`endif
);

  // A settle time of zero still needs one cycle for the register to capture.
  localparam int S1E  = (S1_CYC < 1) ? 1 : S1_CYC;
  localparam int S2E  = (S2_CYC < 1) ? 1 : S2_CYC;
  localparam int S3E  = (S3_CYC < 1) ? 1 : S3_CYC;
  localparam int SMX  = (S1E > S2E) ? ((S1E > S3E) ? S1E : S3E) : ((S2E > S3E) ? S2E : S3E);
  localparam int CW   = (SMX > 1) ? $clog2(SMX) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  logic [3:0] v_reg, v_next;
  logic [1:0] state_reg, state_next;
  logic [2:0] settled;
  logic [2:0] adv;
  logic       drain3;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_settle
      localparam int SE = (gi == 0) ? S1E : ((gi == 1) ? S2E : S3E);
      localparam logic [CW-1:0] LD = CW'(SE - 1);
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (flush) begin
          cnt_reg <= '0;
        end else if (load_en[gi]) begin
          cnt_reg <= LD;
        end else if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - CW'(1);
        end
      end

      assign settled[gi] = v_reg[gi] && (cnt_reg == '0);
    end
  endgenerate

  // Advance decisions ripple from the output slot back to the image buffer,
  // so a slot freed this cycle can be refilled in the same cycle.
  always_comb begin
    drain3   = v_reg[3] && out_ready && !flush;
    adv[2]   = !flush && settled[2] && (!v_reg[3] || drain3);
    adv[1]   = !flush && settled[1] && (!v_reg[2] || adv[2]);
    adv[0]   = !flush && settled[0] && (!v_reg[1] || adv[1]);
    in_ready = !flush && (!v_reg[0] || adv[0]);
    load_en  = {adv, in_valid && in_ready};
    if (flush) begin
      v_next = 4'b0000;
    end else begin
      v_next = load_en | (v_reg & ~{drain3, adv});
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_FLUSH;
    end else begin
      case (state_reg)
        ST_IDLE:   state_next = load_en[0] ? ST_ACTIVE : ST_IDLE;
        ST_ACTIVE: state_next = (v_next != 4'b0000) ? ST_ACTIVE : ST_IDLE;
        ST_FLUSH:  state_next = load_en[0] ? ST_ACTIVE : ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_reg     <= 4'b0000;
      state_reg <= ST_IDLE;
    end else begin
      v_reg     <= v_next;
      state_reg <= state_next;
    end
  end

  assign out_valid = v_reg[3];
  assign busy      = |v_reg;

`ifdef LENET_SEQ_PERF_EN
  logic [15:0] frame_cnt_reg;
  logic [15:0] stall_cnt_reg;

  // Flush deliberately leaves the counters alone; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg <= 16'h0000;
      stall_cnt_reg <= 16'h0000;
    end else begin
      if (drain3) begin
        frame_cnt_reg <= frame_cnt_reg + 16'h0001;
      end
      if (v_reg[3] && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'h0001;
      end
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
